seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter DEAD_CYC, default 500: anode-off cycles at the start of each slot; 0 disables; SHALL be < REFRESH_DIV.
REQ-003 clk  input  1  system clock; single clock domain, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 digits  input  16  four hex nibbles; [3:0] = digit 0 (rightmost).
REQ-006 dp_in  input  4  decimal point per digit, 1 = lit.
REQ-007 blank_in  input  4  per-digit blank, 1 = digit dark.
REQ-008 load  input  1  one-cycle strobe; captures digits/dp_in/blank_in.
REQ-009 an  output  4  anode enables, active-low, one-hot-low or all high.
REQ-010 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal-point cathode, active-low.
REQ-012 digit_sel  output  2  index of the digit currently driven; downstream mux select.
REQ-013 frame_done  output  1  one-cycle pulse at each 3->0 digit wrap.

Function
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick asserted in the cycle count = REFRESH_DIV-1.
REQ-015 Digit index SHALL advance on tick, 0->1->2->3->0.
REQ-016 frame_done SHALL assert in the cycle after the tick that wraps index 3->0, for exactly one cycle.
REQ-017 load SHALL capture inputs into a pending register and set pending_valid; a later load before the wrap overwrites pending.
REQ-018 On a wrap tick with pending_valid, pending SHALL be copied to the active register and pending_valid cleared; display never changes mid-frame.
REQ-019 load coincident with a wrap tick SHALL make the newly presented inputs active at that tick, with pending_valid cleared.
REQ-020 an, seg, dp, digit_sel SHALL be registered, reflecting prescaler/index state one cycle later.
REQ-021 While prescaler count < DEAD_CYC, an SHALL be 4'b1111; seg/dp still show the current digit.
REQ-022 Outside dead time, an[idx] SHALL be 0, others 1, unless active blank[idx] = 1, in which case an = 4'b1111.
REQ-023 seg SHALL be the hex decode of active nibble idx: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; full 0-F table in package.
REQ-024 dp SHALL be ~active_dp[idx].

Reset
REQ-025 On rst: prescaler 0, index 0, active/pending registers 0, pending_valid 0.
REQ-026 On rst outputs SHALL be an=1111, seg=1111111, dp=1, digit_sel=0, frame_done=0 from the next edge; rst mid-frame discards pending load.
REQ-027 After rst deasserts, digit 0 slot starts with prescaler count 0 (dead time first).

Structure
REQ-028 Package seg7_pkg SHALL hold the 16-entry hex-to-segment table, blank constant 7'h7F and anode-off constant 4'hF.
REQ-029 Combinational sub-module seg7_decode (4-bit hex in, 7-bit seg out) SHALL implement the table; the top instantiates it once.
REQ-030 Prescaler width SHALL be derived from REFRESH_DIV via clog2.

Verification (REFRESH_DIV=4, DEAD_CYC=1)
REQ-031 Reset, load digits=16'h1A80 -> after first wrap, slots 0..3 show seg 1000000, 0000000, 0001000, 1111001 with an 1110,1101,1011,0111.
REQ-032 Dead time: first registered cycle of each slot an=1111, remaining 3 cycles one-hot-low.
REQ-033 load 16'hFFFF mid-frame at idx=1 -> digits unchanged until wrap; frame_done pulse precedes first F (0001110).
REQ-034 load coincident with wrap tick, digits=16'h0008 -> slot 0 shows 8 in the new frame, pending_valid=0.
REQ-035 blank_in=4'b0100, dp_in=4'b0001 -> slot 2 an=1111 throughout; slot 0 dp=0, others dp=1.
REQ-036 rst asserted at idx=2 with pending load -> next edge an=1111, seg=1111111; pending discarded, display all 0 after restart.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment scan controller.
// Segment encodings are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Packed table, so index 15 comes first in the concatenation
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    typedef logic [1:0] digit_idx_t;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } frame_t;

    function automatic logic [3:0] anode_onehot_low(input digit_idx_t idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-nibble to seven-segment decoder (active-low cathodes).
module seg7_decode (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed four-digit seven-segment scan controller with per-slot
// anode dead time and frame-synchronous (tear-free) display updates.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);
    import seg7_pkg::*;

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_p0;
    digit_idx_t       idx_p0;
    logic             tick_p0;
    logic             wrap_p0;
    logic             in_dead_p0;

    frame_t           active_p0;
    frame_t           pending_p0;
    logic             pend_vld_p0;
    frame_t           load_frame;

    logic [3:0]       cur_nib_p0;
    logic [6:0]       seg_dec_p0;
    logic [3:0]       an_nxt_p0;

    logic [3:0]       an_p1;
    logic [6:0]       seg_p1;
    logic             dp_p1;
    digit_idx_t       sel_p1;
    logic             fd_p1;

    // ---- stage p0: prescaler and digit index ----
    assign tick_p0 = (cnt_p0 == CNT_MAX);
    assign wrap_p0 = tick_p0 && (idx_p0 == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
            idx_p0 <= '0;
        end else begin
            cnt_p0 <= tick_p0 ? '0 : cnt_p0 + 1'b1;
            if (tick_p0) begin
                idx_p0 <= idx_p0 + 1'b1;
            end
        end
    end

    generate
        if (DEAD_CYC > 0) begin : g_dead
            localparam logic [CNT_W-1:0] DEAD_T = CNT_W'(DEAD_CYC);
            assign in_dead_p0 = (cnt_p0 < DEAD_T);
        end else begin : g_no_dead
            assign in_dead_p0 = 1'b0;
        end
    endgenerate

    // Loads are staged in pending and only promoted at the frame wrap, so a
    // frame is always drawn from one consistent snapshot.
    assign load_frame = '{digits: digits, dp: dp_in, blank: blank_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            active_p0   <= '0;
            pending_p0  <= '0;
            pend_vld_p0 <= 1'b0;
        end else begin
            if (load) begin
                pending_p0 <= load_frame;
            end
            if (wrap_p0) begin
                if (load) begin
                    active_p0 <= load_frame;
                end else if (pend_vld_p0) begin
                    active_p0 <= pending_p0;
                end
                pend_vld_p0 <= 1'b0;
            end else if (load) begin
                pend_vld_p0 <= 1'b1;
            end
        end
    end

    assign cur_nib_p0 = active_p0.digits[{idx_p0, 2'b00} +: 4];

    seg7_decode u_decode (
        .hex (cur_nib_p0),
        .seg (seg_dec_p0)
    );

    assign an_nxt_p0 = (in_dead_p0 || active_p0.blank[idx_p0]) ? AN_OFF
                                                                : anode_onehot_low(idx_p0);

    // ---- stage p1: registered pad drivers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            an_p1  <= AN_OFF;
            seg_p1 <= SEG_BLANK;
            dp_p1  <= 1'b1;
            sel_p1 <= '0;
            fd_p1  <= 1'b0;
        end else begin
            an_p1  <= an_nxt_p0;
            seg_p1 <= seg_dec_p0;
            dp_p1  <= ~active_p0.dp[idx_p0];
            sel_p1 <= idx_p0;
            fd_p1  <= wrap_p0;
        end
    end

    assign an         = an_p1;
    assign seg        = seg_p1;
    assign dp         = dp_p1;
    assign digit_sel  = sel_p1;
    assign frame_done = fd_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed, table-driven bench for seg7_scan_ctrl at REFRESH_DIV=4, DEAD_CYC=1.
module tb_seg7_scan_ctrl;

    localparam int NV = 96;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        ld;
        logic [15:0] dg;
        logic [3:0]  dpi;
        logic [3:0]  bki;
        logic [3:0]  an_e;
        logic [6:0]  seg_e;
        logic        dp_e;
        logic [1:0]  sel_e;
        logic        fd_e;
    } vec_t;

    vec_t vecs [NV];

    seg7_scan_ctrl #(
        .REFRESH_DIV (4),
        .DEAD_CYC    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its summary, expected finish within 1000000 time units");
        $fatal(1, "timeout");
    end

    // Slot c==0 is the single dead cycle; a blanked slot stays dark throughout.
    function automatic logic [3:0] exp_an(input int s, input int c, input logic [3:0] blk);
        logic [3:0] oh;
        oh = 4'(1 << s);
        if (c == 0 || blk[s]) return 4'hF;
        return ~oh;
    endfunction

    task automatic fill_frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dpv, input logic [3:0] blk);
        logic [6:0] sg [4];
        sg[0] = s0; sg[1] = s1; sg[2] = s2; sg[3] = s3;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                int i;
                i = base + s * 4 + c;
                vecs[i].ld    = 1'b0;
                vecs[i].dg    = 16'h0000;
                vecs[i].dpi   = 4'h0;
                vecs[i].bki   = 4'h0;
                vecs[i].an_e  = exp_an(s, c, blk);
                vecs[i].seg_e = sg[s];
                vecs[i].dp_e  = dpv[s];
                vecs[i].sel_e = 2'(s);
                vecs[i].fd_e  = (s == 3 && c == 3);
            end
        end
    endtask

    task automatic set_load(input int i, input logic [15:0] dg, input logic [3:0] dpi,
                            input logic [3:0] bki);
        vecs[i].ld  = 1'b1;
        vecs[i].dg  = dg;
        vecs[i].dpi = dpi;
        vecs[i].bki = bki;
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] dg,
                        input logic [3:0] dpi, input logic [3:0] bki);
        @(negedge clk);
        rst      = r;
        load     = ld;
        digits   = dg;
        dp_in    = dpi;
        blank_in = bki;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] an_e, input logic [6:0] seg_e,
                       input logic dp_e, input logic [1:0] sel_e, input logic fd_e);
        n_checks++;
        if ({an, seg, dp, digit_sel, frame_done} !== {an_e, seg_e, dp_e, sel_e, fd_e}) begin
            n_errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b sel=%0d fd=%b, expected an=%b seg=%b dp=%b sel=%0d fd=%b",
                     name, an, seg, dp, digit_sel, frame_done, an_e, seg_e, dp_e, sel_e, fd_e);
        end
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        digits   = 16'h0000;
        dp_in    = 4'h0;
        blank_in = 4'h0;

        // Frame 0: all zero until the first wrap promotes 1A80
        fill_frame(0,  7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 4'h0);
        set_load(0, 16'h1A80, 4'h0, 4'h0);
        // Frame 1: 1A80, with FFFF loaded mid-frame at idx 1
        fill_frame(16, 7'h40, 7'h00, 7'h08, 7'h79, 4'hF, 4'h0);
        set_load(21, 16'hFFFF, 4'h0, 4'h0);
        // Frame 2: FFFF; EEEE then overwritten by 5432 with dp/blank
        fill_frame(32, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'hF, 4'h0);
        set_load(34, 16'hEEEE, 4'h0, 4'h0);
        set_load(42, 16'h5432, 4'b0001, 4'b0100);
        // Frame 3: 5432, slot 2 blanked, slot 0 dp lit; load on the wrap tick
        fill_frame(48, 7'h24, 7'h30, 7'h19, 7'h12, 4'b1110, 4'b0100);
        set_load(51, 16'h7777, 4'h0, 4'h0);
        set_load(63, 16'h0008, 4'h0, 4'h0);
        // Frames 4 and 5: 0008 straight from the coincident load, and it sticks
        fill_frame(64, 7'h00, 7'h40, 7'h40, 7'h40, 4'hF, 4'h0);
        fill_frame(80, 7'h00, 7'h40, 7'h40, 7'h40, 4'hF, 4'h0);

        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        chk("reset_a", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        chk("reset_b", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            step(1'b0, vecs[i].ld, vecs[i].dg, vecs[i].dpi, vecs[i].bki);
            chk($sformatf("vec%0d", i), vecs[i].an_e, vecs[i].seg_e, vecs[i].dp_e,
                vecs[i].sel_e, vecs[i].fd_e);
        end

        // Pending load, then reset while idx is 2: pending must be discarded
        step(1'b0, 1'b1, 16'hFFFF, 4'hF, 4'h0);
        chk("pre_rst_slot0", 4'hF, 7'h00, 1'b1, 2'd0, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        chk("pre_rst_slot1", 4'b1101, 7'h40, 1'b1, 2'd1, 1'b0);
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        chk("mid_rst_a", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        chk("mid_rst_b", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);

        for (int j = 0; j < 32; j++) begin
            int s;
            int c;
            s = (j / 4) % 4;
            c = j % 4;
            step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
            chk($sformatf("post_rst%0d", j), exp_an(s, c, 4'h0), 7'h40, 1'b1, 2'(s),
                (j % 16) == 15);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
